// File: rtl/mac_dot_seq.sv
// mac_dot_seq: dot-product sequencer pacing operand pairs through a Booth MAC's load/busy/accumulate protocol.
module mac_dot_seq #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 16,
    parameter int LEN_W    = 8,
    parameter int BUSY_TMO = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              start_ready,
    input  logic [LEN_W-1:0]  len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              abort,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_load,
    output logic              mac_clr,
    output logic              mac_acc_en,
    input  logic              mac_busy,
    input  logic [ACC_W-1:0]  mac_acc,
    input  logic              mac_ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  result,
    output logic              res_ovf,
    output logic              res_err
);
    localparam int TMO_W = $clog2(BUSY_TMO + 1);

    typedef enum logic [3:0] {IDLE, CLEAR, FETCH, LOAD, WAIT_HI, WAIT_LO, ACCUM, SETTLE, DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, elem_cnt_q, elem_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [DATA_W-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic              ovf_q, ovf_d, err_q, err_d;
    logic              kill;

    // abort only cancels a job in flight; IDLE and DONE ignore it
    assign kill        = abort && state_q != IDLE && state_q != DONE;
    assign start_ready = state_q == IDLE;
    assign op_ready    = state_q == FETCH && !abort;
    assign mac_load    = state_q == LOAD && !abort;
    assign mac_acc_en  = state_q == ACCUM && !abort;
    assign mac_clr     = state_q == CLEAR || kill;
    assign res_valid   = state_q == DONE;
    assign mac_a       = mac_a_q;
    assign mac_b       = mac_b_q;
    assign result      = result_q;
    assign res_ovf     = ovf_q;
    assign res_err     = err_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        elem_cnt_d = elem_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        mac_a_d    = mac_a_q;
        mac_b_d    = mac_b_q;
        result_d   = result_q;
        err_d      = err_q;
        ovf_d      = (state_q inside {FETCH, LOAD, WAIT_HI, WAIT_LO, ACCUM, SETTLE}) ? ovf_q | mac_ovf : ovf_q;
        case (state_q)
            IDLE: if (start) begin
                len_d   = len;
                ovf_d   = 1'b0;
                err_d   = 1'b0;
                state_d = CLEAR;
            end
            CLEAR: begin
                elem_cnt_d = '0;
                state_d    = (len_q == '0) ? SETTLE : FETCH;
            end
            FETCH: if (op_valid && op_ready) begin
                mac_a_d = op_a;
                mac_b_d = op_b;
                state_d = LOAD;
            end
            LOAD: begin
                tmo_cnt_d = '0;
                state_d   = WAIT_HI;
            end
            WAIT_HI: if (mac_busy) state_d = WAIT_LO;
            else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (tmo_cnt_q == TMO_W'(BUSY_TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            WAIT_LO: if (!mac_busy) state_d = ACCUM;
            ACCUM: begin
                elem_cnt_d = elem_cnt_q + 1'b1;
                state_d    = (elem_cnt_d == len_q) ? SETTLE : FETCH;
            end
            SETTLE: begin
                result_d = mac_acc;
                state_d  = DONE;
            end
            DONE: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            elem_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            mac_a_q    <= '0;
            mac_b_q    <= '0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            elem_cnt_q <= elem_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            mac_a_q    <= mac_a_d;
            mac_b_q    <= mac_b_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq: randomized and directed checks of mac_dot_seq against a MAC stand-in and an arithmetic dot-product reference.
module tb_mac_dot_seq;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, op_valid = 1'b0, abort = 1'b0, res_ready = 1'b0;
    logic [7:0]  len = '0, op_a = '0, op_b = '0;
    logic        start_ready, op_ready, mac_load, mac_clr, mac_acc_en, mac_busy, mac_ovf;
    logic        res_valid, res_ovf, res_err;
    logic [7:0]  mac_a, mac_b;
    logic [15:0] mac_acc, result;

    mac_dot_seq dut (
        .clk(clk), .reset(reset), .start(start), .start_ready(start_ready), .len(len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .abort(abort),
        .mac_a(mac_a), .mac_b(mac_b), .mac_load(mac_load), .mac_clr(mac_clr), .mac_acc_en(mac_acc_en),
        .mac_busy(mac_busy), .mac_acc(mac_acc), .mac_ovf(mac_ovf),
        .res_valid(res_valid), .res_ready(res_ready), .result(result), .res_ovf(res_ovf), .res_err(res_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // MAC stand-in: product latched on load, busy for busy_lat cycles, sticky signed overflow on accumulate
    int          busy_lat = 4;
    bit          no_busy = 0;
    int          busy_cnt = 0;
    logic [15:0] prod = '0, acc_m = '0;
    logic        ovf_m = 1'b0;
    int          sum_m;
    always @(posedge clk) begin
        sum_m = int'($signed(acc_m)) + int'($signed(prod));
        if (mac_clr) begin
            acc_m <= '0;
            ovf_m <= 1'b0;
        end else if (mac_acc_en) begin
            acc_m <= acc_m + prod;
            if (sum_m > 32767 || sum_m < -32768) ovf_m <= 1'b1;
        end
        if (mac_load) begin
            prod     <= 16'(int'($signed(mac_a)) * int'($signed(mac_b)));
            busy_cnt <= busy_lat;
        end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign mac_busy = busy_cnt != 0 && !no_busy;
    assign mac_acc  = acc_m;
    assign mac_ovf  = ovf_m;

    int         n_clr = 0, n_load = 0, n_acc = 0, n_opr = 0, n_rv = 0, stab_bad = 0;
    logic [7:0] la = '0, lb = '0;
    always @(posedge clk) begin
        if (mac_clr) n_clr <= n_clr + 1;
        if (mac_load) n_load <= n_load + 1;
        if (mac_acc_en) n_acc <= n_acc + 1;
        if (op_ready) n_opr <= n_opr + 1;
        if (res_valid) n_rv <= n_rv + 1;
        if (mac_busy && (mac_a !== la || mac_b !== lb)) stab_bad <= stab_bad + 1;
        if (mac_load) begin
            la <= mac_a;
            lb <= mac_b;
        end
    end

    logic [7:0]  a_arr [256], b_arr [256];
    int          idx, gapc, gap_g;
    logic [15:0] j_res, r_res;
    logic        j_ovf, j_err, r_ovf, j_to, j_stable, j_vafter;
    int          j_cyc;

    function automatic void ref_dot(input int n);
        int s = 0, t;
        r_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            t = s + int'($signed(a_arr[i])) * int'($signed(b_arr[i]));
            if (t > 32767 || t < -32768) r_ovf = 1'b1;
            s = int'($signed(16'(t)));
        end
        r_res = 16'(s);
    endfunction

    task automatic step(input int n);
        bit hs;
        op_valid = idx < n && gapc >= gap_g;
        op_a = a_arr[idx[7:0]];
        op_b = b_arr[idx[7:0]];
        hs = op_valid && op_ready;
        @(posedge clk); #1;
        if (hs) begin
            idx++;
            gapc = 0;
        end else gapc++;
    endtask

    task automatic run_job(input int n, input int gap, input int hold);
        idx = 0; gapc = 0; gap_g = gap; j_cyc = 0; j_to = 0; j_stable = 1;
        start = 1'b1; len = 8'(n);
        @(posedge clk); #1;
        start = 1'b0;
        while (!res_valid && !j_to) begin
            step(n);
            j_cyc++;
            if (j_cyc > 5000) j_to = 1;
        end
        op_valid = 1'b0;
        j_res = result; j_ovf = res_ovf; j_err = res_err;
        repeat (hold) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || result !== j_res || res_ovf !== j_ovf || res_err !== j_err) j_stable = 0;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        j_vafter = res_valid;
        tests++;
        if (j_to) begin fails++; $display("FAIL job_timeout: res_valid never rose, len %0d", n); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({start_ready, op_ready, mac_load, mac_clr, mac_acc_en, res_valid, res_ovf, res_err} !== 8'b1000_0000) begin
            fails++; $display("FAIL reset_ctrl: got %b want 10000000", {start_ready, op_ready, mac_load, mac_clr, mac_acc_en, res_valid, res_ovf, res_err});
        end
        tests++;
        if ({mac_a, mac_b, result} !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", {mac_a, mac_b, result}); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int c0 = n_clr, l0 = n_load, a0 = n_acc;
        a_arr[0] = 8'd2; b_arr[0] = 8'd3; a_arr[1] = 8'd4; b_arr[1] = 8'd5; a_arr[2] = 8'hFF; b_arr[2] = 8'd6;
        busy_lat = 4;
        run_job(3, 0, 0);
        tests++; if (j_res !== 16'h0014) begin fails++; $display("FAIL basic_result: got %h want 0014", j_res); end
        tests++; if ({j_ovf, j_err} !== 2'b00) begin fails++; $display("FAIL basic_flags: got %b want 00", {j_ovf, j_err}); end
        tests++; if (n_clr - c0 != 1) begin fails++; $display("FAIL basic_clr: got %0d want 1", n_clr - c0); end
        tests++; if (n_load - l0 != 3) begin fails++; $display("FAIL basic_load: got %0d want 3", n_load - l0); end
        tests++; if (n_acc - a0 != 3) begin fails++; $display("FAIL basic_acc: got %0d want 3", n_acc - a0); end
        // CLEAR + 3 x (FETCH+LOAD+WAIT_HI+WAIT_LO(4 busy cycles total)+ACCUM) + SETTLE
        tests++; if (j_cyc != 2 + 3 * (busy_lat + 4)) begin fails++; $display("FAIL basic_latency: got %0d want %0d", j_cyc, 2 + 3 * (busy_lat + 4)); end
        tests++; if (j_vafter !== 1'b0) begin fails++; $display("FAIL basic_release: res_valid got %b want 0", j_vafter); end
    endtask

    task automatic test_len0;
        int c0 = n_clr, l0 = n_load, o0 = n_opr;
        run_job(0, 0, 0);
        tests++; if (j_res !== 16'h0000) begin fails++; $display("FAIL len0_result: got %h want 0000", j_res); end
        tests++; if (j_cyc != 2) begin fails++; $display("FAIL len0_latency: got %0d want 2", j_cyc); end
        tests++; if (n_clr - c0 != 1 || n_load != l0 || n_opr != o0) begin
            fails++; $display("FAIL len0_pulses: clr %0d load %0d op_ready %0d want 1 0 0", n_clr - c0, n_load - l0, n_opr - o0);
        end
    endtask

    task automatic test_gaps_hold;
        int s0 = stab_bad;
        for (int i = 0; i < 2; i++) begin a_arr[i] = 8'($urandom); b_arr[i] = 8'($urandom); end
        ref_dot(2);
        busy_lat = 6;
        run_job(2, 5, 10);
        tests++; if (j_res !== r_res) begin fails++; $display("FAIL gaps_result: got %h want %h", j_res, r_res); end
        tests++; if (stab_bad != s0) begin fails++; $display("FAIL gaps_operand_hold: %0d unstable busy cycles want 0", stab_bad - s0); end
        tests++; if (!j_stable || j_vafter !== 1'b0) begin fails++; $display("FAIL gaps_result_hold: stable %0d after %b want 1 0", j_stable, j_vafter); end
    endtask

    task automatic test_timeout;
        int a0 = n_acc;
        a_arr[0] = 8'd1; b_arr[0] = 8'd1;
        no_busy = 1;
        run_job(1, 0, 0);
        no_busy = 0;
        tests++; if (j_err !== 1'b1) begin fails++; $display("FAIL tmo_err: got %b want 1", j_err); end
        tests++; if (n_acc != a0) begin fails++; $display("FAIL tmo_acc: got %0d want 0", n_acc - a0); end
        tests++; if (j_cyc != 3 + 15) begin fails++; $display("FAIL tmo_latency: got %0d want 18", j_cyc); end
    endtask

    task automatic test_overflow_back_to_back;
        for (int i = 0; i < 3; i++) begin a_arr[i] = 8'd127; b_arr[i] = 8'd127; end
        busy_lat = 2;
        run_job(3, 0, 0);
        tests++; if (j_res !== 16'hBD03 || j_ovf !== 1'b1) begin fails++; $display("FAIL ovf_job: got %h/%b want bd03/1", j_res, j_ovf); end
        a_arr[0] = 8'd5; b_arr[0] = 8'hFD;
        run_job(1, 0, 0);
        tests++; if (j_res !== 16'hFFF1 || j_ovf !== 1'b0 || j_err !== 1'b0) begin
            fails++; $display("FAIL b2b_job: got %h/%b/%b want fff1/0/0", j_res, j_ovf, j_err);
        end
    endtask

    task automatic test_abort;
        int l0 = n_load, r0, cyc = 0;
        logic clr_seen;
        for (int i = 0; i < 3; i++) begin a_arr[i] = 8'd9; b_arr[i] = 8'd9; end
        busy_lat = 4; idx = 0; gapc = 0; gap_g = 0;
        start = 1'b1; len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        while (n_load - l0 < 2 && cyc < 200) begin step(3); cyc++; end
        op_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        #1 clr_seen = mac_clr;
        @(posedge clk); #1;
        abort = 1'b0;
        r0 = n_rv;
        tests++; if (clr_seen !== 1'b1 || cyc >= 200) begin fails++; $display("FAIL abort_clr: got %b want 1 (cycles %0d)", clr_seen, cyc); end
        tests++; if ({start_ready, op_ready, res_valid} !== 3'b100) begin fails++; $display("FAIL abort_idle: got %b want 100", {start_ready, op_ready, res_valid}); end
        repeat (8) @(posedge clk);
        #1;
        tests++; if (n_rv != r0) begin fails++; $display("FAIL abort_no_result: res_valid cycles %0d want 0", n_rv - r0); end
        a_arr[0] = 8'd3; b_arr[0] = 8'd3;
        run_job(1, 0, 0);
        tests++; if (j_res !== 16'h0009) begin fails++; $display("FAIL abort_next: got %h want 0009", j_res); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin a_arr[i] = 8'd7; b_arr[i] = 8'd7; end
        idx = 0; gapc = 0; gap_g = 0;
        start = 1'b1; len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) step(3);
        op_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests++;
        if ({start_ready, op_ready, mac_load, mac_clr, mac_acc_en, res_valid, mac_a, mac_b} !== {6'b100000, 16'h0}) begin
            fails++; $display("FAIL reset_mid: got %b/%h%h want 100000/0000", {start_ready, op_ready, mac_load, mac_clr, mac_acc_en, res_valid}, mac_a, mac_b);
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        int n, g;
        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(1, 8));
            g = int'($urandom_range(0, 2));
            busy_lat = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin a_arr[i] = 8'($urandom); b_arr[i] = 8'($urandom); end
            ref_dot(n);
            run_job(n, g, int'($urandom_range(0, 3)));
            tests++;
            if (j_res !== r_res || j_ovf !== r_ovf || j_err !== 1'b0) begin
                fails++; $display("FAIL random_%0d: got %h/%b/%b want %h/%b/0", k, j_res, j_ovf, j_err, r_res, r_ovf);
            end
            tests++;
            if (g == 0 && j_cyc != 2 + n * (busy_lat + 4)) begin
                fails++; $display("FAIL random_latency_%0d: got %0d want %0d", k, j_cyc, 2 + n * (busy_lat + 4));
            end
        end
    endtask

    task automatic test_max_len;
        int a0 = n_acc;
        for (int i = 0; i < 255; i++) begin a_arr[i] = 8'($urandom); b_arr[i] = 8'($urandom); end
        ref_dot(255);
        busy_lat = 1;
        run_job(255, 0, 0);
        tests++; if (j_res !== r_res || j_ovf !== r_ovf) begin fails++; $display("FAIL maxlen_result: got %h/%b want %h/%b", j_res, j_ovf, r_res, r_ovf); end
        tests++; if (n_acc - a0 != 255) begin fails++; $display("FAIL maxlen_acc: got %0d want 255", n_acc - a0); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_len0;
        test_gaps_hold;
        test_timeout;
        test_overflow_back_to_back;
        test_abort;
        test_reset_mid;
        test_random;
        test_max_len;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
